// File: rtl/sump_pkg.sv
// Shared constants and state encodings for the SUMP host command receiver.
// Imported by the UART byte receiver and the command assembler.
package sump_pkg;

    localparam logic [7:0] CMD_RESET = 8'h00;
    localparam logic [7:0] CMD_RUN   = 8'h01;
    localparam logic [7:0] CMD_ID    = 8'h02;
    localparam logic [7:0] CMD_XON   = 8'h11;
    localparam logic [7:0] CMD_XOFF  = 8'h13;

    // Bit 7 of an opcode marks a long command carrying a 32-bit argument.
    localparam int LONG_FLAG_BIT = 7;

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_BREAK
    } byte_state_e;

    typedef enum logic {
        C_OPCODE,
        C_ARG
    } cmd_state_e;

    function automatic logic is_long_cmd(input logic [7:0] op);
        return op[LONG_FLAG_BIT];
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 LSB-first UART byte receiver: two-flop synchroniser plus byte FSM.
// byte_valid_o / frame_error_o are combinational strobes in the stop-bit sampling cycle.
module uart_byte_rx
    import sump_pkg::*;
#(
    parameter int FREQ = 100000000,
    parameter int RATE = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trx_clock_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int BITLENGTH = FREQ / RATE;
    localparam int CNTW      = $clog2(BITLENGTH + 1);
    // Each decision fires on the tick that makes the counter reach its target.
    localparam logic [CNTW-1:0] HALF_LAST = CNTW'(BITLENGTH / 2 - 1);
    localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(BITLENGTH - 1);

    logic              rx_meta_q;
    logic              rxs_q;
    byte_state_e       state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              stop_sample;

    // The synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            B_IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = '0;
                    state_d = B_START;
                end
            end
            B_START: begin
                if (trx_clock_i) begin
                    if (cnt_q == HALF_LAST) begin
                        if (!rxs_q) begin
                            cnt_d   = '0;
                            idx_d   = '0;
                            state_d = B_DATA;
                        end else begin
                            state_d = B_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            B_DATA: begin
                if (trx_clock_i) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rxs_q;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = B_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            B_STOP: begin
                if (trx_clock_i) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        state_d = rxs_q ? B_IDLE : B_BREAK;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            B_BREAK: begin
                if (rxs_q) begin
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_comb begin
        stop_sample   = (state_q == B_STOP) && trx_clock_i && (cnt_q == BIT_LAST);
        byte_valid_o  = stop_sample && rxs_q;
        frame_error_o = stop_sample && !rxs_q;
        byte_o        = shift_q;
    end

endmodule

// File: rtl/command_receiver.sv
// SUMP command assembler: turns received bytes into opcode/argument commands
// with an execute strobe, and decodes XON/XOFF into flow-control pulses.
module command_receiver
    import sump_pkg::*;
#(
    parameter int FREQ = 100000000,
    parameter int RATE = 115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trxClock,
    input  logic        rx,
    output logic [7:0]  opcode,
    output logic [31:0] data,
    output logic        execute,
    output logic        xon,
    output logic        xoff,
    output logic        frameError
);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        byte_frame_error;

    cmd_state_e  state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] data_q, data_d;
    logic        execute_q, execute_d;
    logic        xon_q, xon_d;
    logic        xoff_q, xoff_d;
    logic        frame_error_q, frame_error_d;
    logic [7:0]  cmd_op_q, cmd_op_d;
    logic [23:0] arg_q, arg_d;
    logic [1:0]  arg_cnt_q, arg_cnt_d;

    uart_byte_rx #(
        .FREQ (FREQ),
        .RATE (RATE)
    ) u_byte_rx (
        .clock         (clock),
        .reset         (reset),
        .trx_clock_i   (trxClock),
        .rx_i          (rx),
        .byte_o        (rx_byte),
        .byte_valid_o  (byte_valid),
        .frame_error_o (byte_frame_error)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= C_OPCODE;
            opcode_q      <= '0;
            data_q        <= '0;
            execute_q     <= 1'b0;
            xon_q         <= 1'b0;
            xoff_q        <= 1'b0;
            frame_error_q <= 1'b0;
            cmd_op_q      <= '0;
            arg_q         <= '0;
            arg_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            data_q        <= data_d;
            execute_q     <= execute_d;
            xon_q         <= xon_d;
            xoff_q        <= xoff_d;
            frame_error_q <= frame_error_d;
            cmd_op_q      <= cmd_op_d;
            arg_q         <= arg_d;
            arg_cnt_q     <= arg_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            C_OPCODE: begin
                if (byte_valid && is_long_cmd(rx_byte)) begin
                    state_d = C_ARG;
                end
            end
            C_ARG: begin
                // A framing error abandons the partial command silently.
                if (byte_frame_error) begin
                    state_d = C_OPCODE;
                end else if (byte_valid && arg_cnt_q == 2'd3) begin
                    state_d = C_OPCODE;
                end
            end
            default: state_d = C_OPCODE;
        endcase
    end

    always_comb begin
        opcode_d      = opcode_q;
        data_d        = data_q;
        execute_d     = 1'b0;
        xon_d         = 1'b0;
        xoff_d        = 1'b0;
        frame_error_d = byte_frame_error;
        cmd_op_d      = cmd_op_q;
        arg_d         = arg_q;
        arg_cnt_d     = arg_cnt_q;
        if (byte_valid) begin
            unique case (state_q)
                C_OPCODE: begin
                    if (rx_byte == CMD_XON) begin
                        xon_d = 1'b1;
                    end else if (rx_byte == CMD_XOFF) begin
                        xoff_d = 1'b1;
                    end else if (!is_long_cmd(rx_byte)) begin
                        opcode_d  = rx_byte;
                        data_d    = '0;
                        execute_d = 1'b1;
                    end else begin
                        cmd_op_d  = rx_byte;
                        arg_cnt_d = '0;
                    end
                end
                C_ARG: begin
                    // Argument arrives LSB byte first; XON/XOFF values are plain data here.
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    unique case (arg_cnt_q)
                        2'd0: arg_d[7:0]   = rx_byte;
                        2'd1: arg_d[15:8]  = rx_byte;
                        2'd2: arg_d[23:16] = rx_byte;
                        default: begin
                            opcode_d  = cmd_op_q;
                            data_d    = {rx_byte, arg_q};
                            execute_d = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign opcode     = opcode_q;
    assign data       = data_q;
    assign execute    = execute_q;
    assign xon        = xon_q;
    assign xoff       = xoff_q;
    assign frameError = frame_error_q;

endmodule

// File: tb/tb_command_receiver.sv
// Scoreboard bench for command_receiver at 16 clocks per bit with trxClock held high.
// Expected pulses are queued as bytes are sent and popped when the DUT pulses.
module tb_command_receiver;

    localparam int BL = 16;
    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_EXEC = 4'b1000;
    localparam logic [3:0] K_XON  = 4'b0100;
    localparam logic [3:0] K_XOFF = 4'b0010;
    localparam logic [3:0] K_FE   = 4'b0001;
    // Pulse must land one clock after a mid-stop-bit sample, allowing for synchroniser delay.
    localparam int LAT_MIN = 150;
    localparam int LAT_MAX = 160;

    typedef struct {
        logic [3:0]  kind;
        logic [7:0]  op;
        logic [31:0] data;
        int          start;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        trxClock;
    logic        rx;
    logic [7:0]  opcode;
    logic [31:0] data;
    logic        execute;
    logic        xon;
    logic        xoff;
    logic        frameError;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        sb[$];
    logic [7:0]  model_op   = 8'h00;
    logic [31:0] model_data = 32'h0;

    command_receiver #(
        .FREQ (16),
        .RATE (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .trxClock   (trxClock),
        .rx         (rx),
        .opcode     (opcode),
        .data       (data),
        .execute    (execute),
        .xon        (xon),
        .xoff       (xoff),
        .frameError (frameError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (execute || xon || xoff || frameError) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: got {exec,xon,xoff,fe}=%b at cycle %0d, required no pulse",
                             {execute, xon, xoff, frameError}, cyc);
                end else begin
                    e = sb.pop_front();
                    if ({execute, xon, xoff, frameError} !== e.kind) begin
                        bad++;
                        $display("FAIL pulse_kind: got %b required %b", {execute, xon, xoff, frameError}, e.kind);
                    end
                    total++;
                    if (opcode !== e.op) begin
                        bad++;
                        $display("FAIL opcode: got %h required %h", opcode, e.op);
                    end
                    total++;
                    if (data !== e.data) begin
                        bad++;
                        $display("FAIL data: got %h required %h", data, e.data);
                    end
                    total++;
                    if (cyc - e.start < LAT_MIN || cyc - e.start > LAT_MAX) begin
                        bad++;
                        $display("FAIL latency: got %0d cycles after start edge, required %0d..%0d",
                                 cyc - e.start, LAT_MIN, LAT_MAX);
                    end
                end
            end
        end
    endtask

    // Called on a falling clock edge; drives one full 8N1 frame.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic [3:0] kind,
                             input logic [7:0] op, input logic [31:0] d);
        exp_t e;
        if (kind == K_EXEC) begin
            model_op   = op;
            model_data = d;
        end
        if (kind != K_NONE) begin
            e.kind  = kind;
            e.op    = model_op;
            e.data  = model_data;
            e.start = cyc;
            sb.push_back(e);
        end
        rx = 1'b0;
        repeat (BL) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BL) @(negedge clock);
        end
        rx = stop;
        repeat (BL) @(negedge clock);
        rx = 1'b1;
        if (!stop) repeat (2 * BL) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({opcode, data, execute, xon, xoff, frameError} !== 44'd0) begin
            bad++;
            $display("FAIL reset_outputs: got op=%h data=%h pulses=%b required all zero",
                     opcode, data, {execute, xon, xoff, frameError});
        end
        reset = 1'b1;
        repeat (3 * BL) @(negedge clock);
        total++;
        if ({opcode, data} !== 40'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got op=%h data=%h required zero", opcode, data);
        end
    endtask

    task automatic test_short();
        send_byte(8'h01, 1'b1, K_EXEC, 8'h01, 32'h0);
        repeat (3 * BL) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL short_missing: pending=%0d required 0", sb.size());
            sb.delete();
        end
        total++;
        if (opcode !== 8'h01 || data !== 32'h0) begin
            bad++;
            $display("FAIL short_hold: got op=%h data=%h required 01/00000000", opcode, data);
        end
    endtask

    task automatic test_long();
        send_byte(8'hC0, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h78, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h56, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h34, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h12, 1'b1, K_EXEC, 8'hC0, 32'h12345678);
        repeat (3 * BL) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL long_missing: pending=%0d required 0", sb.size());
            sb.delete();
        end
        total++;
        if (opcode !== 8'hC0 || data !== 32'h12345678) begin
            bad++;
            $display("FAIL long_hold: got op=%h data=%h required c0/12345678", opcode, data);
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (3 * BL) @(negedge clock);
        send_byte(8'h02, 1'b1, K_EXEC, 8'h02, 32'h0);
        repeat (3 * BL) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL glitch_missing: pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_frame_error();
        send_byte(8'h80, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h55, 1'b0, K_FE, 8'h00, 32'h0);
        send_byte(8'h01, 1'b1, K_EXEC, 8'h01, 32'h0);
        repeat (3 * BL) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL frame_missing: pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_flow_control();
        send_byte(8'h13, 1'b1, K_XOFF, 8'h00, 32'h0);
        send_byte(8'h11, 1'b1, K_XON, 8'h00, 32'h0);
        send_byte(8'h81, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h11, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h13, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h00, 1'b1, K_NONE, 8'h00, 32'h0);
        send_byte(8'h00, 1'b1, K_EXEC, 8'h81, 32'h00001311);
        repeat (3 * BL) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL flow_missing: pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h34;
        send_byte(8'h81, 1'b1, K_NONE, 8'h00, 32'h0);
        rx = 1'b0;
        repeat (BL) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            rx = b[i];
            repeat (BL) @(negedge clock);
        end
        rx = b[2];
        repeat (BL / 2) @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if ({opcode, data, execute, xon, xoff, frameError} !== 44'd0) begin
            bad++;
            $display("FAIL async_reset: got op=%h data=%h pulses=%b required all zero",
                     opcode, data, {execute, xon, xoff, frameError});
        end
        model_op   = 8'h00;
        model_data = 32'h0;
        @(negedge clock);
        rx = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (2 * BL) @(negedge clock);
        send_byte(8'h01, 1'b1, K_EXEC, 8'h01, 32'h0);
        repeat (3 * BL) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_missing: pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset    = 1'b0;
        rx       = 1'b1;
        trxClock = 1'b1;
        fork
            monitor();
        join_none
        @(negedge clock);
        test_reset();
        test_short();
        test_long();
        test_glitch();
        test_frame_error();
        test_flow_control();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
